// File: rtl/inst_dispatcher_if.sv
// Instruction, command and write-back channels between the receiver, the dispatcher and the
// execution unit.
interface inst_dispatcher_if #(
    parameter int unsigned INSTRUCTION_DEPTH = 16
) ();
    localparam int unsigned ID_W = (INSTRUCTION_DEPTH > 1) ? $clog2(INSTRUCTION_DEPTH) : 1;

    logic [63:0]     instruction;
    logic [ID_W-1:0] instruction_id;
    logic            instruction_valid;
    logic            instruction_next;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_flags;
    logic [47:0]     cmd_operand;
    logic [ID_W-1:0] cmd_id;
    logic            exec_done;
    logic [47:0]     exec_result;
    logic [63:0]     data;
    logic [ID_W-1:0] data_id;
    logic            data_valid;

    modport master (
        input  instruction, instruction_id, instruction_valid,
        output instruction_next,
        output cmd_valid, cmd_flags, cmd_operand, cmd_id,
        input  cmd_ready,
        input  exec_done, exec_result,
        output data, data_id, data_valid
    );

    modport slave (
        output instruction, instruction_id, instruction_valid,
        input  instruction_next,
        input  cmd_valid, cmd_flags, cmd_operand, cmd_id,
        output cmd_ready,
        output exec_done, exec_result,
        input  data, data_id, data_valid
    );
endinterface

// File: rtl/inst_dispatcher.sv
// Decodes one instruction at a time, issues EXEC commands, waits for completion (with timeout)
// and writes a tagged status word back to the receiver.
module inst_dispatcher #(
    parameter int unsigned DATA_WIDTH        = 64,
    parameter int unsigned INSTRUCTION_DEPTH = 16,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_enable,
    inst_dispatcher_if.master   bus,
    output logic                o_busy,
    output logic [15:0]         o_err_count
);
    localparam int unsigned ID_W    = (INSTRUCTION_DEPTH > 1) ? $clog2(INSTRUCTION_DEPTH) : 1;
    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_EXEC = 8'h01;

    localparam logic [3:0] ST_OK      = 4'd0;
    localparam logic [3:0] ST_ILLEGAL = 4'd1;
    localparam logic [3:0] ST_TIMEOUT = 4'd2;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_opcode;
    logic [7:0]            r_flags;
    logic [47:0]           r_operand;
    logic [ID_W-1:0]       r_id;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [15:0]           r_err_count;

    logic       w_fetch;
    logic [7:0] w_opcode;
    logic       w_is_exec;
    logic       w_is_nop;
    logic       w_timeout;

    assign w_opcode  = bus.instruction[63:56];
    assign w_is_exec = (w_opcode == OP_EXEC);
    assign w_is_nop  = (w_opcode == OP_NOP);
    assign w_fetch   = (r_state == StIdle) & bus.instruction_valid & i_enable & ~rst;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_fetch) begin
                    w_state_next = w_is_exec ? StIssue : StWb;
                end
            end
            StIssue: begin
                if (bus.cmd_ready) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (bus.exec_done || w_timeout) begin
                    w_state_next = StWb;
                end
            end
            StWb: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode    <= '0;
            r_flags     <= '0;
            r_operand   <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_data      <= '0;
            r_err_count <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_fetch) begin
                        r_opcode  <= w_opcode;
                        r_flags   <= bus.instruction[55:48];
                        r_operand <= bus.instruction[47:0];
                        r_id      <= bus.instruction_id;
                        // NOP and ILLEGAL complete immediately; their status is known now.
                        if (!w_is_exec) begin
                            r_data <= {w_opcode, (w_is_nop ? ST_OK : ST_ILLEGAL), 4'd0, 48'd0};
                        end
                    end
                end
                StIssue: begin
                    if (bus.cmd_ready) begin
                        r_cnt <= '0;
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (bus.exec_done) begin
                        r_data <= {r_opcode, ST_OK, 4'd0, bus.exec_result};
                    end else if (w_timeout) begin
                        r_data <= {r_opcode, ST_TIMEOUT, 4'd0, 48'd0};
                    end
                end
                StWb: begin
                    if ((r_data[55:52] != ST_OK) && (r_err_count != 16'hFFFF)) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.instruction_next = w_fetch;
    assign bus.cmd_valid        = (r_state == StIssue);
    assign bus.cmd_flags        = r_flags;
    assign bus.cmd_operand      = r_operand;
    assign bus.cmd_id           = r_id;
    assign bus.data             = r_data[63:0];
    assign bus.data_id          = r_id;
    assign bus.data_valid       = (r_state == StWb);
    assign o_busy               = (r_state != StIdle);
    assign o_err_count          = r_err_count;
endmodule

// File: tb/tb_inst_dispatcher.sv
// Directed, table-driven bench for inst_dispatcher with hand-written timeout/reset sequences.
module tb_inst_dispatcher;
    logic        clk;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] err_count;

    inst_dispatcher_if #(.INSTRUCTION_DEPTH(16)) bus ();

    inst_dispatcher #(
        .DATA_WIDTH       (64),
        .INSTRUCTION_DEPTH(16),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (enable),
        .bus        (bus),
        .o_busy     (busy),
        .o_err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [3:0]  id;
        int          ready_dly;
        int          done_dly;
        logic [47:0] result;
        logic [63:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];
    int   n_checks;
    int   n_errors;
    int   exp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bus.instruction       = v.word;
        bus.instruction_id    = v.id;
        bus.instruction_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.instruction_next && n < 20) begin
            step();
            n++;
        end
        check("next_pulse", bus.instruction_next, 1);
        step();
        bus.instruction_valid = 1'b0;
        if (v.word[63:56] == 8'h01) begin
            check("cmd_valid", bus.cmd_valid, 1);
            check("cmd_operand", bus.cmd_operand, v.word[47:0]);
            check("cmd_flags", bus.cmd_flags, v.word[55:48]);
            check("cmd_id", bus.cmd_id, v.id);
            for (int i = 0; i < v.ready_dly; i++) begin
                step();
                check("cmd_hold", {bus.cmd_valid, bus.cmd_operand}, {1'b1, v.word[47:0]});
            end
            bus.cmd_ready = 1'b1;
            step();
            bus.cmd_ready = 1'b0;
            check("cmd_drop", bus.cmd_valid, 0);
            for (int i = 0; i < v.done_dly; i++) step();
            bus.exec_done   = 1'b1;
            bus.exec_result = v.result;
            step();
            bus.exec_done   = 1'b0;
            bus.exec_result = '0;
        end
        check("data_valid", bus.data_valid, 1);
        check("data", bus.data, v.exp_data);
        check("data_id", bus.data_id, v.id);
        if (v.exp_err) exp_err++;
        step();
        check("wb_one_cycle", {bus.data_valid, busy}, 2'b00);
        check("err_count", err_count, exp_err);
    endtask

    // Fetch an EXEC and complete the command handshake; returns at the first WAIT cycle.
    task automatic start_exec(input logic [63:0] word, input logic [3:0] id);
        bus.instruction       = word;
        bus.instruction_id    = id;
        bus.instruction_valid = 1'b1;
        #1;
        check("exec_next", bus.instruction_next, 1);
        step();
        bus.instruction_valid = 1'b0;
        bus.cmd_ready         = 1'b1;
        step();
        bus.cmd_ready         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw_dv;
        n_checks = 0;
        n_errors = 0;
        exp_err  = 0;

        vecs[0] = '{64'h0000_0000_0000_0000, 4'd3, 0, 0, 48'h0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[1] = '{64'h01AA_0000_1234_5678, 4'd5, 4, 2, 48'hBEEF, 64'h0100_0000_0000_BEEF, 1'b0};
        vecs[2] = '{64'h7F12_3456_789A_BCDE, 4'd9, 0, 0, 48'h0, 64'h7F10_0000_0000_0000, 1'b1};
        vecs[3] = '{64'h0155_ABCD_EF01_2345, 4'd15, 0, 0, 48'hFFFF_FFFF_FFFF,
                    64'h0100_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{64'h0077_1111_2222_3333, 4'd0, 0, 0, 48'h0, 64'h0000_0000_0000_0000, 1'b0};
        vecs[5] = '{64'h0201_0000_0000_0005, 4'd1, 0, 0, 48'h0, 64'h0210_0000_0000_0000, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd14, 0, 0, 48'h0, 64'hFF10_0000_0000_0000, 1'b1};
        vecs[7] = '{64'h0180_0000_0000_0042, 4'd6, 1, 6, 48'h1234_5678_9ABC,
                    64'h0100_1234_5678_9ABC, 1'b0};

        rst                   = 1'b1;
        enable                = 1'b1;
        bus.instruction       = 64'h0100_0000_0000_0001;
        bus.instruction_id    = 4'd2;
        bus.instruction_valid = 1'b1;
        bus.cmd_ready         = 1'b0;
        bus.exec_done         = 1'b0;
        bus.exec_result       = '0;
        repeat (3) step();
        check("rst_next", bus.instruction_next, 0);
        check("rst_cmd", {bus.cmd_valid, bus.cmd_flags, bus.cmd_operand, bus.cmd_id}, 0);
        check("rst_data", {bus.data_valid, bus.data_id}, 0);
        check("rst_data_word", bus.data, 0);
        check("rst_busy_err", {busy, err_count}, 0);
        bus.instruction_valid = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Held-off fetch while disabled
        enable                = 1'b0;
        bus.instruction       = 64'h0000_0000_0000_0000;
        bus.instruction_id    = 4'd8;
        bus.instruction_valid = 1'b1;
        #1;
        check("dis_next", bus.instruction_next, 0);
        repeat (3) step();
        check("dis_hold", {bus.instruction_next, busy}, 2'b00);
        bus.instruction_valid = 1'b0;
        enable = 1'b1;
        step();

        // Back-to-back NOPs: fetch, WB, then fetch again on the following cycle
        bus.instruction       = 64'h0000_0000_0000_0000;
        bus.instruction_id    = 4'd10;
        bus.instruction_valid = 1'b1;
        #1;
        check("b2b_next0", bus.instruction_next, 1);
        step();
        bus.instruction_id = 4'd11;
        #1;
        check("b2b_wb", {bus.data_valid, bus.instruction_next, bus.data_id}, {2'b10, 4'd10});
        step();
        check("b2b_next1", bus.instruction_next, 1);
        step();
        bus.instruction_valid = 1'b0;
        check("b2b_wb2", {bus.data_valid, bus.data_id}, {1'b1, 4'd11});
        step();

        // Timeout: exactly 8 WAIT cycles then a TIMEOUT status
        start_exec(64'h0100_0000_0000_0001, 4'd7);
        n = 0;
        while (!bus.data_valid && n < 30) begin
            step();
            n++;
        end
        check("to_wait_cycles", n, 8);
        check("to_data", bus.data, 64'h0120_0000_0000_0000);
        check("to_data_id", bus.data_id, 4'd7);
        exp_err++;
        step();
        check("to_busy", busy, 0);
        check("to_err", err_count, exp_err);

        // Completion on the final timeout cycle wins
        start_exec(64'h0100_0000_0000_0002, 4'd2);
        repeat (7) step();
        bus.exec_done   = 1'b1;
        bus.exec_result = 48'h0000_0000_0ABC;
        step();
        bus.exec_done   = 1'b0;
        bus.exec_result = '0;
        check("coin_data", {bus.data_valid, bus.data}, {1'b1, 64'h0100_0000_0000_0ABC});
        step();
        check("coin_err", err_count, exp_err);

        // Reset while waiting discards the op
        start_exec(64'h0100_0000_0000_0003, 4'd4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_err = 0;
        check("rstw_cmd", {bus.cmd_valid, bus.cmd_operand, bus.cmd_id}, 0);
        check("rstw_out", {bus.data_valid, busy, bus.data_id, err_count}, 0);
        check("rstw_data", bus.data, 0);
        saw_dv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.data_valid) saw_dv = 1'b1;
        end
        check("rstw_no_wb", saw_dv, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
